scan_test_ctrl: RTL

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_pkg.sv | 14 +
 rtl/scan_test_ctrl_if.sv | 28 ++
 rtl/scan_shreg.sv | 36 +++
 rtl/scan_test_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/scan_test_pkg.sv
// Shared types for the scan test controller: FSM state encoding and default chain length.
package scan_test_pkg;

    localparam int CHAIN_LEN_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_e;

endpackage

// File: rtl/scan_test_ctrl_if.sv
// Host request/result signals plus the scan chain pins; slave is the controller side.
interface scan_test_ctrl_if
    import scan_test_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
    logic [CHAIN_LEN-1:0] mask;
    logic                 SE;
    logic                 SI;
    logic                 SO;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] response;

    modport slave (
        input  start, pattern, expected, mask, SO,
        output SE, SI, busy, done, pass, response
    );

    modport master (
        output start, pattern, expected, mask, SO,
        input  SE, SI, busy, done, pass, response
    );
endinterface

// File: rtl/scan_shreg.sv
// Parallel-load shift register, shifts toward bit 0 with serial input at the top bit.
// Load has priority over shift; used both as pattern serializer and response deserializer.
module scan_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] par_o
);
    logic [WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_dat_i;
        end else if (shift_i) begin
            sh_d = {ser_i, sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign ser_o = sh_q[0];
    assign par_o = sh_q;
endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: load pattern, one capture cycle, unload and compare under mask.
// SE/SI are registered so they change on the same edge as the state.
module scan_test_ctrl
    import scan_test_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST,
    scan_test_ctrl_if.slave bus
);
    localparam int            CW   = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;

    logic                 load_en, ser_shift, des_shift, ser_bit, last_bit;
    logic [CHAIN_LEN-1:0] resp, resp_next;
    logic [CHAIN_LEN-1:0] ser_par_unused;
    logic                 des_ser_unused;

    assign last_bit  = (cnt_q == LAST);
    // Response including the bit sampled on this edge, so pass is ready with done.
    assign resp_next = {bus.SO, resp[CHAIN_LEN-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        se_d      = 1'b0;
        si_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        exp_d     = exp_q;
        mask_d    = mask_q;
        load_en   = 1'b0;
        ser_shift = 1'b0;
        des_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                    se_d    = 1'b1;
                    si_d    = bus.pattern[0];
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    exp_d   = bus.expected;
                    mask_d  = bus.mask;
                    load_en = 1'b1;
                end
            end
            SHIFT_IN: begin
                ser_shift = 1'b1;
                if (last_bit) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    se_d  = 1'b1;
                    si_d  = ser_bit;
                end
            end
            CAPTURE: begin
                state_d = SHIFT_OUT;
                se_d    = 1'b1;
            end
            SHIFT_OUT: begin
                des_shift = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (((resp_next ^ exp_q) & mask_q) == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    se_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            exp_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
        end
    end

    // Bit 0 goes straight to SI on the accepting edge, so the serializer holds the rest.
    scan_shreg #(.WIDTH(CHAIN_LEN)) u_ser (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (load_en),
        .load_dat_i ({1'b0, bus.pattern[CHAIN_LEN-1:1]}),
        .shift_i    (ser_shift),
        .ser_i      (1'b0),
        .ser_o      (ser_bit),
        .par_o      (ser_par_unused)
    );

    scan_shreg #(.WIDTH(CHAIN_LEN)) u_des (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (load_en),
        .load_dat_i ('0),
        .shift_i    (des_shift),
        .ser_i      (bus.SO),
        .ser_o      (des_ser_unused),
        .par_o      (resp)
    );

    assign bus.SE       = se_q;
    assign bus.SI       = si_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.response = resp;
endmodule
